// File: rtl/lane_pkg.sv
// Shared types and sizing helpers for the lane scan controller and its tap datapath.
package lane_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Headroom above the pixel width: three taps of up to |8| each, plus sign.
    localparam int TAP_GUARD_BITS = 6;

    function automatic int res_w(input int pix_w);
        return pix_w + TAP_GUARD_BITS;
    endfunction

    function automatic int pos_w(input int row_len);
        return (row_len - 2 > 1) ? $clog2(row_len - 2) : 1;
    endfunction

    function automatic int row_w(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    function automatic logic [31:0] sat_conf(input logic [31:0] mag, input int conf_w);
        logic [31:0] lim;
        lim = (32'd1 << conf_w) - 32'd1;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/lane_scan_controller_edge_tap3.sv
// Combinational 3-tap signed filter over a two-pixel window plus the incoming pixel,
// producing the absolute value of the response one bit wider than the sum.
module edge_tap3
    import lane_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int K0    = -1,
    parameter int K1    = 0,
    parameter int K2    = 1
)(
    input  logic [PIX_W-1:0]        i_pixN2,
    input  logic [PIX_W-1:0]        i_pixN1,
    input  logic [PIX_W-1:0]        i_pixN,
    output logic [res_w(PIX_W):0]   o_mag
);

    localparam int RES_W = res_w(PIX_W);

    localparam logic signed [RES_W-1:0] C0 = RES_W'(K0);
    localparam logic signed [RES_W-1:0] C1 = RES_W'(K1);
    localparam logic signed [RES_W-1:0] C2 = RES_W'(K2);

    logic signed [RES_W-1:0] w_xN2;
    logic signed [RES_W-1:0] w_xN1;
    logic signed [RES_W-1:0] w_xN;
    logic signed [RES_W-1:0] w_resp;
    logic signed [RES_W:0]   w_wide;

    // Pixels are unsigned, so they enter the signed sum zero-extended.
    assign w_xN2 = $signed({{(RES_W-PIX_W){1'b0}}, i_pixN2});
    assign w_xN1 = $signed({{(RES_W-PIX_W){1'b0}}, i_pixN1});
    assign w_xN  = $signed({{(RES_W-PIX_W){1'b0}}, i_pixN});

    assign w_resp = (C0 * w_xN2) + (C1 * w_xN1) + (C2 * w_xN);

    // Negating at one extra bit keeps the most-negative response representable.
    assign w_wide = {w_resp[RES_W-1], w_resp};
    assign o_mag  = w_wide[RES_W] ? $unsigned(-w_wide) : $unsigned(w_wide);

endmodule

// File: rtl/lane_scan_controller.sv
// Streams pixel rows, tracks the strongest 3-tap edge per row and reports
// position, saturated confidence and a threshold flag for every row of a frame.
module lane_scan_controller
    import lane_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int ROW_LEN  = 32,
    parameter int NUM_ROWS = 1,
    parameter int K0       = -1,
    parameter int K1       = 0,
    parameter int K2       = 1,
    parameter int CONF_W   = 8,
    parameter int THRESH   = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [PIX_W-1:0]              rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [pos_w(ROW_LEN)-1:0]     tx_pos,
    output logic [CONF_W-1:0]             tx_conf,
    output logic                          tx_lane_found,
    output logic [row_w(NUM_ROWS)-1:0]    tx_row,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int RES_W = res_w(PIX_W);
    localparam int MAG_W = RES_W + 1;
    localparam int POS_W = pos_w(ROW_LEN);
    localparam int ROW_W = row_w(NUM_ROWS);
    localparam int CNT_W = $clog2(ROW_LEN + 1);

    state_t             r_state;
    state_t             w_nextState;

    logic [CNT_W-1:0]   r_pixCnt;
    logic [PIX_W-1:0]   r_winN1;
    logic [PIX_W-1:0]   r_winN2;
    logic [MAG_W-1:0]   r_maxMag;
    logic [POS_W-1:0]   r_maxPos;
    logic [ROW_W-1:0]   r_row;
    logic [POS_W-1:0]   r_txPos;
    logic [CONF_W-1:0]  r_txConf;
    logic               r_txFound;
    logic               r_frameDone;

    logic [MAG_W-1:0]   w_mag;
    logic               w_rxFire;
    logic               w_txFire;
    logic               w_lastPix;
    logic               w_lastRow;
    logic               w_takeMax;
    logic [POS_W-1:0]   w_respIdx;
    logic [MAG_W-1:0]   w_finalMag;
    logic [POS_W-1:0]   w_finalPos;

    edge_tap3 #(
        .PIX_W (PIX_W),
        .K0    (K0),
        .K1    (K1),
        .K2    (K2)
    ) u_tap (
        .i_pixN2 (r_winN2),
        .i_pixN1 (r_winN1),
        .i_pixN  (rx_data),
        .o_mag   (w_mag)
    );

    assign w_rxFire  = rx_valid && (r_state == RECEIVE);
    assign w_txFire  = tx_ready && (r_state == REPORT);
    assign w_lastPix = (r_pixCnt == CNT_W'(ROW_LEN - 1));
    assign w_lastRow = (r_row == ROW_W'(NUM_ROWS - 1));
    assign w_respIdx = POS_W'(r_pixCnt - CNT_W'(2));

    // Index 0 always loads; later indices need a strictly larger magnitude so ties keep the earliest.
    assign w_takeMax  = (r_pixCnt >= CNT_W'(2)) &&
                        ((r_pixCnt == CNT_W'(2)) || (w_mag > r_maxMag));
    assign w_finalMag = w_takeMax ? w_mag : r_maxMag;
    assign w_finalPos = w_takeMax ? w_respIdx : r_maxPos;

    assign tx_pos        = r_txPos;
    assign tx_conf       = r_txConf;
    assign tx_lane_found = r_txFound;
    assign tx_row        = r_row;
    assign frame_done    = r_frameDone;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RECEIVE;
                end
            end
            RECEIVE: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (w_rxFire && w_lastPix) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (w_txFire) begin
                    w_nextState = w_lastRow ? IDLE : RECEIVE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Window, argmax and result registers; results are latched on the final pixel so they hold through REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixCnt    <= '0;
            r_winN1     <= '0;
            r_winN2     <= '0;
            r_maxMag    <= '0;
            r_maxPos    <= '0;
            r_row       <= '0;
            r_txPos     <= '0;
            r_txConf    <= '0;
            r_txFound   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pixCnt <= '0;
                        r_row    <= '0;
                        r_maxMag <= '0;
                        r_maxPos <= '0;
                    end
                end
                RECEIVE: begin
                    if (w_rxFire) begin
                        r_winN2  <= r_winN1;
                        r_winN1  <= rx_data;
                        r_pixCnt <= r_pixCnt + CNT_W'(1);
                        if (w_takeMax) begin
                            r_maxMag <= w_mag;
                            r_maxPos <= w_respIdx;
                        end
                        if (w_lastPix) begin
                            r_txPos   <= w_finalPos;
                            r_txConf  <= CONF_W'(sat_conf(32'(w_finalMag), CONF_W));
                            r_txFound <= (w_finalMag >= MAG_W'(THRESH));
                        end
                    end
                end
                REPORT: begin
                    if (w_txFire) begin
                        if (w_lastRow) begin
                            r_frameDone <= 1'b1;
                        end else begin
                            r_row    <= r_row + ROW_W'(1);
                            r_pixCnt <= '0;
                            r_maxMag <= '0;
                            r_maxPos <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_scan_controller.sv
// Self-checking bench: three parameterisations share stimulus lines; a row-level
// argmax model computes every expected result from the raw pixel rows.
module tb_lane_scan_controller;

    logic       clk;
    logic       rst;
    logic [7:0] rxData;
    logic       rxValid;
    logic       txReady;
    logic       startReq;
    int         curSel;

    logic       startA, startB, startC;
    logic       aRxReady, aFound, aTxValid, aFrameDone, aBusy;
    logic [4:0] aPos;
    logic [7:0] aConf;
    logic [0:0] aRow;
    logic       bRxReady, bFound, bTxValid, bFrameDone, bBusy;
    logic [2:0] bPos;
    logic [7:0] bConf;
    logic [1:0] bRow;
    logic       cRxReady, cFound, cTxValid, cFrameDone, cBusy;
    logic [0:0] cPos;
    logic [3:0] cConf;
    logic [0:0] cRow;

    int obsRxReady, obsPos, obsConf, obsFound, obsRow, obsTxValid, obsFrameDone, obsBusy;

    int rowLenTab[3]  = '{32, 8, 4};
    int numRowsTab[3] = '{1, 3, 2};
    int k0Tab[3]      = '{-1, -7, 2};
    int k1Tab[3]      = '{0, 0, -3};
    int k2Tab[3]      = '{1, 7, 1};
    int confMaxTab[3] = '{255, 255, 15};
    int threshTab[3]  = '{16, 16, 5};

    int rowBuf[3][32];
    int recPos[3];
    int recConf[3];
    int recFound[3];

    int checks = 0;
    int errors = 0;

    assign startA = startReq && (curSel == 0);
    assign startB = startReq && (curSel == 1);
    assign startC = startReq && (curSel == 2);

    lane_scan_controller dutA (
        .clk(clk), .rst(rst), .start(startA), .rx_data(rxData), .rx_valid(rxValid),
        .rx_ready(aRxReady), .tx_pos(aPos), .tx_conf(aConf), .tx_lane_found(aFound),
        .tx_row(aRow), .tx_valid(aTxValid), .tx_ready(txReady), .frame_done(aFrameDone),
        .busy(aBusy)
    );

    lane_scan_controller #(.ROW_LEN(8), .NUM_ROWS(3), .K0(-7), .K1(0), .K2(7)) dutB (
        .clk(clk), .rst(rst), .start(startB), .rx_data(rxData), .rx_valid(rxValid),
        .rx_ready(bRxReady), .tx_pos(bPos), .tx_conf(bConf), .tx_lane_found(bFound),
        .tx_row(bRow), .tx_valid(bTxValid), .tx_ready(txReady), .frame_done(bFrameDone),
        .busy(bBusy)
    );

    lane_scan_controller #(.ROW_LEN(4), .NUM_ROWS(2), .K0(2), .K1(-3), .K2(1),
                           .CONF_W(4), .THRESH(5)) dutC (
        .clk(clk), .rst(rst), .start(startC), .rx_data(rxData), .rx_valid(rxValid),
        .rx_ready(cRxReady), .tx_pos(cPos), .tx_conf(cConf), .tx_lane_found(cFound),
        .tx_row(cRow), .tx_valid(cTxValid), .tx_ready(txReady), .frame_done(cFrameDone),
        .busy(cBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obsRxReady = 0; obsPos = 0; obsConf = 0; obsFound = 0;
        obsRow = 0; obsTxValid = 0; obsFrameDone = 0; obsBusy = 0;
        case (curSel)
            0: begin
                obsRxReady = int'(aRxReady); obsPos = int'(aPos); obsConf = int'(aConf);
                obsFound = int'(aFound); obsRow = int'(aRow); obsTxValid = int'(aTxValid);
                obsFrameDone = int'(aFrameDone); obsBusy = int'(aBusy);
            end
            1: begin
                obsRxReady = int'(bRxReady); obsPos = int'(bPos); obsConf = int'(bConf);
                obsFound = int'(bFound); obsRow = int'(bRow); obsTxValid = int'(bTxValid);
                obsFrameDone = int'(bFrameDone); obsBusy = int'(bBusy);
            end
            default: begin
                obsRxReady = int'(cRxReady); obsPos = int'(cPos); obsConf = int'(cConf);
                obsFound = int'(cFound); obsRow = int'(cRow); obsTxValid = int'(cTxValid);
                obsFrameDone = int'(cFrameDone); obsBusy = int'(cBusy);
            end
        endcase
    end

    // Whole-row reference: absolute response per index, earliest strict maximum.
    function automatic void model(input int sel, input int r, output int pos,
                                  output int conf, output int found);
        int best;
        int v;
        best = -1;
        pos  = 0;
        for (int i = 0; i < rowLenTab[sel] - 2; i++) begin
            v = k0Tab[sel] * rowBuf[r][i] + k1Tab[sel] * rowBuf[r][i+1] + k2Tab[sel] * rowBuf[r][i+2];
            if (v < 0) v = -v;
            if (v > best) begin
                best = v;
                pos  = i;
            end
        end
        conf  = (best > confMaxTab[sel]) ? confMaxTab[sel] : best;
        found = (best >= threshTab[sel]) ? 1 : 0;
    endfunction

    task automatic pulse_start();
        startReq = 1'b1;
        @(posedge clk); #1;
        startReq = 1'b0;
        checks++;
        if (obsBusy !== 1) begin
            errors++;
            $display("FAIL start_busy sel=%0d got=%0d want=1", curSel, obsBusy);
        end
    endtask

    task automatic feed_pixel(input int pix, input bit gaps);
        int  guard;
        bit  acc;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) begin
                rxValid  = 1'b0;
                rxData   = 8'($urandom);
                startReq = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        rxValid  = 1'b1;
        rxData   = 8'(pix);
        startReq = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 20) begin
            acc = (obsRxReady == 1);
            @(posedge clk); #1;
            guard++;
        end
        rxValid  = 1'b0;
        startReq = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout sel=%0d got=no_accept want=accept", curSel);
        end
    endtask

    task automatic run_frame(input int sel, input int hold, input bit gaps);
        int len, nRows, ePos, eConf, eFound;
        curSel = sel;
        len    = rowLenTab[sel];
        nRows  = numRowsTab[sel];
        pulse_start();
        for (int r = 0; r < nRows; r++) begin
            for (int n = 0; n < len; n++) begin
                feed_pixel(rowBuf[r][n], gaps);
                if (n == len - 2) begin
                    checks++;
                    if (obsTxValid !== 0) begin
                        errors++;
                        $display("FAIL early_valid sel=%0d row=%0d got=%0d want=0", sel, r, obsTxValid);
                    end
                end
            end
            model(sel, r, ePos, eConf, eFound);
            checks++;
            if (obsTxValid !== 1) begin
                errors++;
                $display("FAIL valid_latency sel=%0d row=%0d got=%0d want=1", sel, r, obsTxValid);
            end
            checks++;
            if (obsPos !== ePos) begin
                errors++;
                $display("FAIL pos sel=%0d row=%0d got=%0d want=%0d", sel, r, obsPos, ePos);
            end
            checks++;
            if (obsConf !== eConf) begin
                errors++;
                $display("FAIL conf sel=%0d row=%0d got=%0d want=%0d", sel, r, obsConf, eConf);
            end
            checks++;
            if (obsFound !== eFound) begin
                errors++;
                $display("FAIL found sel=%0d row=%0d got=%0d want=%0d", sel, r, obsFound, eFound);
            end
            checks++;
            if (obsRow !== r) begin
                errors++;
                $display("FAIL row_index sel=%0d got=%0d want=%0d", sel, obsRow, r);
            end
            recPos[r]   = obsPos;
            recConf[r]  = obsConf;
            recFound[r] = obsFound;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checks++;
                if (obsTxValid !== 1 || obsRxReady !== 0) begin
                    errors++;
                    $display("FAIL hold_handshake sel=%0d row=%0d got=valid%0d/ready%0d want=valid1/ready0",
                             sel, r, obsTxValid, obsRxReady);
                end
                checks++;
                if (obsPos !== ePos || obsConf !== eConf || obsFound !== eFound || obsRow !== r) begin
                    errors++;
                    $display("FAIL hold_stable sel=%0d row=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                             sel, r, obsPos, obsConf, obsFound, obsRow, ePos, eConf, eFound, r);
                end
            end
            txReady = 1'b1;
            @(posedge clk); #1;
            txReady = 1'b0;
            checks++;
            if (obsTxValid !== 0) begin
                errors++;
                $display("FAIL valid_drop sel=%0d row=%0d got=%0d want=0", sel, r, obsTxValid);
            end
            checks++;
            if (obsFrameDone !== ((r == nRows - 1) ? 1 : 0)) begin
                errors++;
                $display("FAIL frame_done sel=%0d row=%0d got=%0d want=%0d", sel, r, obsFrameDone,
                         (r == nRows - 1) ? 1 : 0);
            end
            if (r == nRows - 1) begin
                @(posedge clk); #1;
                checks++;
                if (obsFrameDone !== 0 || obsBusy !== 0) begin
                    errors++;
                    $display("FAIL frame_done_once sel=%0d got=done%0d/busy%0d want=done0/busy0",
                             sel, obsFrameDone, obsBusy);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        for (int s = 0; s < 3; s++) begin
            curSel = s;
            #0;
            checks++;
            if (obsRxReady !== 0 || obsTxValid !== 0 || obsPos !== 0 || obsConf !== 0 ||
                obsFound !== 0 || obsRow !== 0 || obsFrameDone !== 0 || obsBusy !== 0) begin
                errors++;
                $display("FAIL %s sel=%0d got=rdy%0d val%0d pos%0d conf%0d fnd%0d row%0d done%0d busy%0d want=all0",
                         name, s, obsRxReady, obsTxValid, obsPos, obsConf, obsFound, obsRow,
                         obsFrameDone, obsBusy);
            end
        end
    endtask

    task automatic check_record(input string name, input int r, input int p, input int c, input int f);
        checks++;
        if (recPos[r] !== p || recConf[r] !== c || recFound[r] !== f) begin
            errors++;
            $display("FAIL %s got=%0d/%0d/%0d want=%0d/%0d/%0d", name, recPos[r], recConf[r],
                     recFound[r], p, c, f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rxValid = 1'b0; rxData = '0; txReady = 1'b0; startReq = 1'b0; curSel = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_rising_edge();
        for (int i = 0; i < 32; i++) rowBuf[0][i] = (i < 16) ? 0 : 255;
        run_frame(0, 2, 1'b0);
        check_record("rising_edge", 0, 14, 255, 1);
    endtask

    task automatic test_falling_edge();
        for (int i = 0; i < 32; i++) rowBuf[0][i] = (i < 10) ? 200 : 0;
        run_frame(0, 1, 1'b0);
        check_record("falling_edge", 0, 8, 200, 1);
    endtask

    task automatic test_tie_earliest();
        for (int i = 0; i < 32; i++) rowBuf[0][i] = (i >= 7 && i <= 21) ? 50 : 0;
        run_frame(0, 0, 1'b0);
        check_record("tie_earliest", 0, 5, 50, 1);
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 32; i++) rowBuf[0][i] = (i < 20) ? 0 : 16;
        run_frame(0, 0, 1'b0);
        check_record("thresh_equal", 0, 18, 16, 1);
        for (int i = 0; i < 32; i++) rowBuf[0][i] = (i < 20) ? 0 : 15;
        run_frame(0, 0, 1'b0);
        check_record("thresh_below", 0, 18, 15, 0);
    endtask

    task automatic test_multirow();
        for (int i = 0; i < 8; i++) begin
            rowBuf[0][i] = (i < 4) ? 0 : 255;
            rowBuf[1][i] = 16;
            rowBuf[2][i] = $urandom_range(0, 255);
        end
        run_frame(1, 5, 1'b1);
        check_record("saturate_row0", 0, 2, 255, 1);
        check_record("flat_row1", 1, 0, 0, 0);
    endtask

    task automatic test_short_row();
        rowBuf[0][0] = 255; rowBuf[0][1] = 0; rowBuf[0][2] = 0; rowBuf[0][3] = 0;
        rowBuf[1][0] = 0;   rowBuf[1][1] = 0; rowBuf[1][2] = 1; rowBuf[1][3] = 1;
        run_frame(2, 1, 1'b1);
        check_record("short_sat", 0, 0, 15, 1);
        check_record("short_small", 1, 1, 2, 0);
    endtask

    task automatic test_abort();
        curSel = 0;
        pulse_start();
        for (int n = 0; n < 17; n++) feed_pixel((n < 3) ? 0 : 255, 1'b0);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rowBuf[0][i] = $urandom_range(0, 40);
        run_frame(0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < 3; s++) begin
                int hi;
                hi = ($urandom_range(0, 1) == 1) ? 255 : 12;
                for (int r = 0; r < numRowsTab[s]; r++)
                    for (int i = 0; i < rowLenTab[s]; i++)
                        rowBuf[r][i] = $urandom_range(0, hi);
                run_frame(s, $urandom_range(0, 3), 1'b1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_rising_edge();
        test_falling_edge();
        test_tie_earliest();
        test_threshold();
        test_multirow();
        test_short_row();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
